// File: rtl/result_formatter_pkg.sv
// Shared types and constants for the result formatter and its BCD converter.
package result_formatter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        CONVERT = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam int unsigned MAG_BITS   = 14;
    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_BITS   = 4 * BCD_DIGITS;
    localparam int unsigned DISP_MAX   = 9999;
    localparam logic [3:0]  OVF_DIGIT  = 4'hE;

    // Displayed result: digits from thousands (d1) down to units (d4).
    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [3:0] d4;
        logic       sign;
        logic       zero;
    } disp_t;

    localparam disp_t DISP_BLANK = '{d1: 4'd0, d2: 4'd0, d3: 4'd0, d4: 4'd0,
                                     sign: 1'b0, zero: 1'b1};

    // Double-dabble correction for one BCD digit before the shift.
    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble: converts a MAG_BITS binary value to BCD_DIGITS digits,
// one input bit per clock. The first bit is consumed on the start edge, so done
// is high in the cycle right after the last of MAG_BITS steps.
module bin2bcd_seq
    import result_formatter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MAG_BITS-1:0] bin,
    output logic                done,
    output logic [BCD_BITS-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(MAG_BITS + 1);

    logic [CNT_W-1:0]    cnt;
    logic                active;
    logic [MAG_BITS-1:0] sh;
    logic [BCD_BITS-1:0] src_bcd;
    logic [BCD_BITS-1:0] adj_bcd;
    logic [MAG_BITS-1:0] src_sh;

    // One dabble step on either the fresh operand (start) or the running state.
    always_comb begin
        src_bcd = start ? '0 : bcd;
        src_sh  = start ? bin : sh;
        adj_bcd = src_bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            adj_bcd[i*4 +: 4] = dabble(src_bcd[i*4 +: 4]);
        end
    end

    // Shift register, step counter and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
            sh     <= '0;
            bcd    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd    <= {adj_bcd[BCD_BITS-2:0], src_sh[MAG_BITS-1]};
                sh     <= {src_sh[MAG_BITS-2:0], 1'b0};
                cnt    <= CNT_W'(1);
                active <= 1'b1;
            end else if (active) begin
                bcd <= {adj_bcd[BCD_BITS-2:0], src_sh[MAG_BITS-1]};
                sh  <= {src_sh[MAG_BITS-2:0], 1'b0};
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(MAG_BITS - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/result_formatter.sv
// Assembles two-byte signed results from the UART, converts them to four BCD
// digits plus sign/zero flags for the display, with timeout and clear handling.
module result_formatter
    import result_formatter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       rxdDataReady,
    input  logic       clear,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       sign,
    output logic       clcZero,
    output logic       busy,
    output logic       frameDrop
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t              state, state_n;
    logic [7:0]          hi_r, hi_n;
    logic [7:0]          lo_r, lo_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic                neg_r, neg_n;
    logic                ovf_r, ovf_n;
    disp_t               disp_r, disp_n;
    logic                busy_n;
    logic                drop_n;
    logic                start_c;
    logic [15:0]         value_c;
    logic [15:0]         mag_c;
    disp_t               conv_disp_c;
    logic                conv_done;
    logic [BCD_BITS-1:0] conv_bcd;

    // Magnitude of the frame being completed by the current low byte.
    always_comb begin
        value_c = {hi_r, data};
        mag_c   = value_c[15] ? 16'(16'd0 - value_c) : value_c;
    end

    // Display word produced once the serial conversion has finished.
    always_comb begin
        if (ovf_r) begin
            conv_disp_c = '{d1: OVF_DIGIT, d2: OVF_DIGIT, d3: OVF_DIGIT, d4: OVF_DIGIT,
                            sign: neg_r, zero: 1'b0};
        end else begin
            conv_disp_c = '{d1: conv_bcd[15:12], d2: conv_bcd[11:8],
                            d3: conv_bcd[7:4],   d4: conv_bcd[3:0],
                            sign: neg_r, zero: ({hi_r, lo_r} == 16'd0)};
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .bin   (mag_c[MAG_BITS-1:0]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Next-state and next-output decisions for the frame FSM.
    always_comb begin
        state_n  = state;
        hi_n     = hi_r;
        lo_n     = lo_r;
        to_cnt_n = to_cnt;
        neg_n    = neg_r;
        ovf_n    = ovf_r;
        disp_n   = disp_r;
        drop_n   = 1'b0;
        start_c  = 1'b0;

        case (state)
            IDLE: begin
                if (clear) begin
                    disp_n = DISP_BLANK;
                end else if (rxdDataReady) begin
                    hi_n     = data;
                    to_cnt_n = '0;
                    state_n  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (clear) begin
                    disp_n   = DISP_BLANK;
                    to_cnt_n = '0;
                    state_n  = IDLE;
                end else if (rxdDataReady) begin
                    lo_n    = data;
                    neg_n   = value_c[15];
                    ovf_n   = (mag_c > 16'(DISP_MAX));
                    start_c = 1'b1;
                    state_n = CONVERT;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    drop_n   = 1'b1;
                    to_cnt_n = '0;
                    state_n  = IDLE;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            CONVERT: begin
                drop_n = rxdDataReady;
                if (conv_done) begin
                    state_n = UPDATE;
                end
            end
            UPDATE: begin
                drop_n  = rxdDataReady;
                disp_n  = conv_disp_c;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == CONVERT) || (state_n == UPDATE);
    end

    // State, latched bytes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hi_r      <= '0;
            lo_r      <= '0;
            to_cnt    <= '0;
            neg_r     <= 1'b0;
            ovf_r     <= 1'b0;
            disp_r    <= DISP_BLANK;
            busy      <= 1'b0;
            frameDrop <= 1'b0;
        end else begin
            state     <= state_n;
            hi_r      <= hi_n;
            lo_r      <= lo_n;
            to_cnt    <= to_cnt_n;
            neg_r     <= neg_n;
            ovf_r     <= ovf_n;
            disp_r    <= disp_n;
            busy      <= busy_n;
            frameDrop <= drop_n;
        end
    end

    assign num1    = disp_r.d1;
    assign num2    = disp_r.d2;
    assign num3    = disp_r.d3;
    assign num4    = disp_r.d4;
    assign sign    = disp_r.sign;
    assign clcZero = disp_r.zero;

endmodule

// File: tb/tb_result_formatter.sv
// Bench for result_formatter: cycle-stamped transaction model plus directed
// vectors with literal expectations.
module tb_result_formatter;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic [3:0] num1, num2, num3, num4;
    logic       sign, clcZero, busy, frameDrop;

    int tests = 0;
    int fails = 0;

    result_formatter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .rxdDataReady (rdy),
        .clear        (clr),
        .num1         (num1),
        .num2         (num2),
        .num3         (num3),
        .num4         (num4),
        .sign         (sign),
        .clcZero      (clcZero),
        .busy         (busy),
        .frameDrop    (frameDrop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected display word from the frame value: {digits, sign, zero}.
    function automatic logic [17:0] fmt(input logic [7:0] h, input logic [7:0] l);
        logic signed [15:0] s;
        int v, m;
        logic neg;
        s   = {h, l};
        v   = int'(s);
        neg = (v < 0);
        m   = neg ? -v : v;
        if (m > 9999) return {16'hEEEE, neg, 1'b0};
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10), neg, (m == 0)};
    endfunction

    // Transaction model: cycle index "now" of the cycle that follows each edge.
    int         now = 0;
    int         tcur = 0;
    int         acc = -100;
    int         wait_entry = 0;
    bit         waiting = 0;
    bit         pend = 0;
    bit         m_ok = 0;
    logic [7:0] m_hi = 8'h00;
    logic [17:0] pend_v = '0;
    logic [15:0] e_dig = '0;
    logic       e_sign = 1'b0;
    logic       e_zero = 1'b1;
    logic       e_busy = 1'b0;
    logic       e_drop = 1'b0;

    always @(posedge clk) begin
        tcur = now;
        now++;
        e_drop = 1'b0;
        if (reset) begin
            e_dig = '0; e_sign = 1'b0; e_zero = 1'b1;
            waiting = 0; pend = 0; acc = -100; m_ok = 1;
        end else begin
            if (pend && now == acc + 16) begin
                {e_dig, e_sign, e_zero} = pend_v;
                pend = 0;
            end
            if (tcur >= acc + 1 && tcur <= acc + 15) begin
                if (rdy) e_drop = 1'b1;
            end else if (clr) begin
                e_dig = '0; e_sign = 1'b0; e_zero = 1'b1;
                waiting = 0;
            end else if (waiting) begin
                if (rdy) begin
                    acc = tcur; pend = 1; pend_v = fmt(m_hi, data); waiting = 0;
                end else if (tcur - wait_entry == TO - 1) begin
                    waiting = 0; e_drop = 1'b1;
                end
            end else if (rdy) begin
                waiting = 1; m_hi = data; wait_entry = tcur + 1;
            end
        end
        e_busy = (now >= acc + 1 && now <= acc + 15);
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_ok)
                chk($sformatf("cycle%0d", now),
                    32'({num1, num2, num3, num4, sign, clcZero, busy, frameDrop}),
                    32'({e_dig, e_sign, e_zero, e_busy, e_drop}));
        end
    end

    task automatic strobe(input logic [7:0] b);
        data = b; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_disp(input string name, input logic [15:0] d, input logic s, input logic z);
        chk(name, 32'({num1, num2, num3, num4, sign, clcZero}), 32'({d, s, z}));
    endtask

    // Called mid cycle T+1 after the low-byte strobe.
    task automatic finish_check(input string name, input logic [15:0] d, input logic s, input logic z);
        chk({name, "_busy_t1"}, 32'(busy), 32'd1);
        idle(14);
        chk({name, "_busy_t15"}, 32'(busy), 32'd1);
        idle(1);
        chk({name, "_busy_t16"}, 32'(busy), 32'd0);
        chk_disp(name, d, s, z);
    endtask

    task automatic frame_check(input string name, input logic [7:0] h, input logic [7:0] l,
                               input logic [15:0] d, input logic s, input logic z);
        strobe(h);
        strobe(l);
        finish_check(name, d, s, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; data = 8'h00; rdy = 1'b0; clr = 1'b0;
        idle(2);
        reset = 1'b0;
        chk_disp("reset_disp", 16'h0000, 1'b0, 1'b1);
        chk("reset_busy_drop", 32'({busy, frameDrop}), 32'd0);

        frame_check("f_123",   8'h00, 8'h7B, 16'h0123, 1'b0, 1'b0);
        frame_check("f_m123",  8'hFF, 8'h85, 16'h0123, 1'b1, 1'b0);
        frame_check("f_zero",  8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
        frame_check("f_9999",  8'h27, 8'h0F, 16'h9999, 1'b0, 1'b0);
        frame_check("f_10000", 8'h27, 8'h10, 16'hEEEE, 1'b0, 1'b0);
        frame_check("f_min",   8'h80, 8'h00, 16'hEEEE, 1'b1, 1'b0);

        // Timeout after the 20th WAIT_LO cycle; display must not change.
        strobe(8'h01);
        idle(19);
        chk("to_no_drop_early", 32'(frameDrop), 32'd0);
        idle(1);
        chk("to_drop", 32'(frameDrop), 32'd1);
        chk_disp("to_disp_kept", 16'hEEEE, 1'b1, 1'b0);
        idle(1);
        chk("to_drop_1cyc", 32'(frameDrop), 32'd0);
        frame_check("f_5", 8'h00, 8'h05, 16'h0005, 1'b0, 1'b0);

        // Low byte arriving in the timeout cycle wins.
        strobe(8'hFF);
        idle(19);
        strobe(8'hFE);
        chk("race_no_drop", 32'(frameDrop), 32'd0);
        finish_check("f_race_m2", 16'h0002, 1'b1, 1'b0);

        // Strobe while busy is dropped with a pulse.
        strobe(8'h00);
        strobe(8'h2A);
        idle(2);
        strobe(8'h55);
        chk("busy_strobe_drop", 32'(frameDrop), 32'd1);
        idle(12);
        chk_disp("busy_strobe_res", 16'h0042, 1'b0, 1'b0);

        // Clear while busy is ignored.
        strobe(8'h00);
        strobe(8'h2B);
        idle(2);
        pulse_clr();
        idle(12);
        chk_disp("busy_clear_res", 16'h0043, 1'b0, 1'b0);

        // Reset in the middle of a conversion.
        strobe(8'h04);
        strobe(8'hD2);
        idle(7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_disp("rst_mid_disp", 16'h0000, 1'b0, 1'b1);
        idle(8);
        chk_disp("rst_mid_later", 16'h0000, 1'b0, 1'b1);
        chk("rst_mid_busy", 32'(busy), 32'd0);

        // Clear in IDLE after a result.
        frame_check("f_123b", 8'h00, 8'h7B, 16'h0123, 1'b0, 1'b0);
        pulse_clr();
        chk_disp("idle_clear", 16'h0000, 1'b0, 1'b1);

        // Clear aborts WAIT_LO without a drop pulse.
        frame_check("f_m1", 8'hFF, 8'hFF, 16'h0001, 1'b1, 1'b0);
        strobe(8'h12);
        pulse_clr();
        chk("wait_clear_no_drop", 32'(frameDrop), 32'd0);
        chk_disp("wait_clear_disp", 16'h0000, 1'b0, 1'b1);

        // Clear and strobe together in WAIT_LO: clear wins, byte lost.
        strobe(8'h12);
        data = 8'h34; rdy = 1'b1; clr = 1'b1;
        @(negedge clk);
        rdy = 1'b0; clr = 1'b0;
        chk("wait_both_no_drop", 32'(frameDrop), 32'd0);
        idle(1);
        chk("wait_both_idle", 32'(busy), 32'd0);

        // Clear and strobe together in IDLE, then a clean frame.
        data = 8'h99; rdy = 1'b1; clr = 1'b1;
        @(negedge clk);
        rdy = 1'b0; clr = 1'b0;
        frame_check("f_4660", 8'h12, 8'h34, 16'h4660, 1'b0, 1'b0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_formatter.md
RESULT_FORMATTER -- requirements
Module: result_formatter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of clocks allowed between the high and low byte of a frame.
REQ-002 SHALL have port clk, input, 1, the single system clock. All logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, active-high synchronous reset.
REQ-004 SHALL have port data, input, 8, a received UART byte, valid only when rxdDataReady=1.
REQ-005 SHALL have port rxdDataReady, input, 1, a one-cycle strobe marking a valid byte.
REQ-006 SHALL have port clear, input, 1, a one-cycle request to blank the result.
REQ-007 SHALL have ports num1, num2, num3 and num4, output, 4 each, the displayed digits from thousands (num1) down to units (num4), for the display driver.
REQ-008 SHALL have port sign, output, 1, set to 1 when the displayed result is negative.
REQ-009 SHALL have port clcZero, output, 1, set to 1 when the displayed result is zero.
REQ-010 SHALL have port busy, output, 1, set to 1 while a frame is being converted.
REQ-011 SHALL have port frameDrop, output, 1, a one-cycle pulse when a byte or frame is discarded.

Function
REQ-012 A frame SHALL be 2 bytes: the high byte first, then the low byte, forming a 16-bit two's-complement result.
REQ-013 The state machine SHALL have the states IDLE, WAIT_LO, CONVERT and UPDATE.
REQ-014 IDLE SHALL move to WAIT_LO on a strobe, latching the byte as the high byte.
REQ-015 WAIT_LO SHALL move to CONVERT on a strobe, latching the low byte; the strobe cycle is T.
REQ-016 The WAIT_LO timeout counter SHALL start at 0 on entry. When it reaches TIMEOUT_CYCLES-1 with no strobe, the FSM SHALL return to IDLE, pulse frameDrop and leave the outputs unchanged.
REQ-017 If a strobe arrives in the same cycle as the timeout, the strobe SHALL win and be treated as the low byte.
REQ-018 On entering CONVERT the block SHALL compute magnitude = abs(value) and the negative flag = value[15].
REQ-019 Overflow SHALL be defined as magnitude > 9999, which includes -32768.
REQ-020 Conversion SHALL be a serial double-dabble over a 14-bit magnitude, one bit per clock, 14 clocks in total.
REQ-021 UPDATE SHALL take 1 clock and then return to IDLE.
REQ-022 The new outputs SHALL become visible exactly at cycle T+16 and hold until the next update, clear or reset.
REQ-023 On overflow, num1 to num4 SHALL all be 4'hE, sign SHALL equal the negative flag, and clcZero SHALL be 0.
REQ-024 Without overflow, the digits SHALL be the BCD value of the magnitude including leading zeros, sign SHALL equal the negative flag, and clcZero SHALL be 1 only when the value is 0.
REQ-025 busy SHALL be 1 in the CONVERT and UPDATE states and 0 otherwise.
REQ-026 A strobe while busy=1 SHALL be ignored, pulse frameDrop, and not start a new frame.
REQ-027 clear SHALL set the digits to 0, sign to 0 and clcZero to 1 on the next edge.
REQ-028 clear SHALL abort WAIT_LO and return the FSM to IDLE without pulsing frameDrop.
REQ-029 clear SHALL be ignored while busy=1.
REQ-030 If clear and a strobe occur in the same cycle in IDLE or WAIT_LO, clear SHALL win and the byte is dropped without a frameDrop pulse.

Reset
REQ-031 Reset SHALL take priority over all other inputs and put the FSM in IDLE.
REQ-032 Reset SHALL zero num1 to num4, sign, the counters and the latched bytes.
REQ-033 Reset SHALL set clcZero to 1, busy to 0 and frameDrop to 0.
REQ-034 Reset during CONVERT SHALL abort the frame without updating the outputs.

Structure
REQ-035 The shared package result_formatter_pkg SHALL hold the FSM state type, MAG_BITS=14, DISP_MAX=9999 and OVF_DIGIT=4'hE.
REQ-036 The serial converter SHALL be the sub-module bin2bcd_seq, with a start/done handshake, a 14-bit input and 4 BCD digits as output.

Verification
REQ-037 Bytes 8'h00 then 8'h7B SHALL give digits 0,1,2,3, sign=0 and clcZero=0 at T+16, with busy=1 from T+1 to T+15.
REQ-038 Bytes 8'hFF then 8'h85 (-123) SHALL give digits 0,1,2,3 with sign=1; bytes 8'h00 then 8'h00 SHALL give digits 0,0,0,0 with clcZero=1.
REQ-039 Bytes 8'h27 then 8'h0F SHALL give 9,9,9,9; bytes 8'h27 then 8'h10 SHALL give E,E,E,E with sign=0; bytes 8'h80 then 8'h00 SHALL give E,E,E,E with sign=1.
REQ-040 With TIMEOUT_CYCLES=20, a high byte 8'h01 followed by silence SHALL pulse frameDrop at the 20th cycle of WAIT_LO; the next bytes 8'h00 then 8'h05 SHALL then display 0,0,0,5.
REQ-041 A strobe at T+3 SHALL be ignored with a frameDrop pulse and the result SHALL be unaffected; clear at T+3 SHALL be ignored.
REQ-042 Reset at T+8 SHALL leave the outputs at reset values; clear in IDLE after a display of 0123 SHALL give 0,0,0,0 with clcZero=1.
